// File: rtl/echo_pkg.sv
// echo_pkg: shared definitions for the echo time-of-flight detector.
//   - SAMPLE_W_DEF / CNT_W_DEF : default sample and counter widths
//   - CH_LEFT / CH_RIGHT       : channel-select encodings ({left, right} word)
//   - state_e                  : measurement FSM states
package echo_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int CNT_W_DEF    = 16;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/echo_mag.sv
// echo_mag: selects one channel of a stereo word and produces its magnitude.
// Optional feature macro: ECHO_AVG_EN (4-tap moving average of the magnitude).
// Ports:
//   clk, srst  - clock and synchronous active-high reset (history only)
//   ch_sel     - CH_LEFT picks data[2*SAMPLE_W-1:SAMPLE_W], CH_RIGHT the low half
//   data       - stereo word {left, right}
//   clr        - zero the averaging history (measurement start)
//   upd        - shift the current magnitude into the history
//   mag        - magnitude of the current sample (averaged when ECHO_AVG_EN)
module echo_mag
  import echo_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  ch_sel,
  input  logic [2*SAMPLE_W-1:0] data,
  input  logic                  clr,
  input  logic                  upd,
  output logic [SAMPLE_W-2:0]   mag
);

  logic [SAMPLE_W-1:0] sample_s;
  logic [SAMPLE_W-1:0] neg_s;
  logic [SAMPLE_W-2:0] raw_mag_s;

  // Channel select and saturating absolute value.
  always_comb begin
    if (ch_sel == CH_RIGHT) begin
      sample_s = data[SAMPLE_W-1:0];
    end else begin
      sample_s = data[2*SAMPLE_W-1:SAMPLE_W];
    end
    neg_s = ~sample_s + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    if (sample_s[SAMPLE_W-1]) begin
      // Only the most negative value still has its MSB set after negation.
      if (neg_s[SAMPLE_W-1]) begin
        raw_mag_s = {(SAMPLE_W-1){1'b1}};
      end else begin
        raw_mag_s = neg_s[SAMPLE_W-2:0];
      end
    end else begin
      raw_mag_s = sample_s[SAMPLE_W-2:0];
    end
  end

`ifdef ECHO_AVG_EN
  logic [SAMPLE_W-2:0] h0_q, h1_q, h2_q;
  logic [SAMPLE_W-2:0] h0_d, h1_d, h2_d;
  logic [SAMPLE_W:0]   sum_s;

  // Average = (current + three previous magnitudes) / 4, two guard bits.
  always_comb begin
    sum_s = {2'b00, raw_mag_s} + {2'b00, h0_q} + {2'b00, h1_q} + {2'b00, h2_q};
    mag   = sum_s[SAMPLE_W:2];
  end

  // History next-state: clear at measurement start, shift per sample.
  always_comb begin
    h0_d = h0_q;
    h1_d = h1_q;
    h2_d = h2_q;
    if (clr) begin
      h0_d = {(SAMPLE_W-1){1'b0}};
      h1_d = {(SAMPLE_W-1){1'b0}};
      h2_d = {(SAMPLE_W-1){1'b0}};
    end else if (upd) begin
      h0_d = raw_mag_s;
      h1_d = h0_q;
      h2_d = h1_q;
    end else begin
      h0_d = h0_q;
    end
  end

  // History registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      h0_q <= {(SAMPLE_W-1){1'b0}};
      h1_q <= {(SAMPLE_W-1){1'b0}};
      h2_q <= {(SAMPLE_W-1){1'b0}};
    end else begin
      h0_q <= h0_d;
      h1_q <= h1_d;
      h2_q <= h2_d;
    end
  end
`else
  logic unused_s;

  // Raw magnitude goes straight through; history controls have no effect.
  always_comb begin
    mag      = raw_mag_s;
    unused_s = ^{clk, srst, clr, upd};
  end
`endif

endmodule

// File: rtl/echo_tof_detector.sv
// echo_tof_detector: drains the record FIFO and, after a trigger, reports the
// sample index of the first echo whose magnitude exceeds a threshold.
// Optional feature macro: ECHO_AVG_EN (compare a 4-tap averaged magnitude).
// Ports:
//   bus_clk, srst            - clock, synchronous active-high reset
//   fifo_rd_en/data/empty    - record FIFO read port (data valid cycle after rd_en)
//   trig_valid/trig_ready    - measurement start handshake (ready only in IDLE)
//   ch_sel, threshold,
//   blank_len, max_samples   - configuration, latched at the trigger
//   res_valid/res_ready      - result handshake
//   res_hit, res_tof, res_peak - echo found flag, sample index, magnitude
module echo_tof_detector
  import echo_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                  bus_clk,
  input  logic                  srst,
  output logic                  fifo_rd_en,
  input  logic [2*SAMPLE_W-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  trig_valid,
  output logic                  trig_ready,
  input  logic                  ch_sel,
  input  logic [SAMPLE_W-2:0]   threshold,
  input  logic [CNT_W-1:0]      blank_len,
  input  logic [CNT_W-1:0]      max_samples,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic [CNT_W-1:0]      res_tof,
  output logic [SAMPLE_W-2:0]   res_peak
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ch_sel_q, ch_sel_d;
  logic [SAMPLE_W-2:0] thr_q, thr_d;
  logic [CNT_W-1:0]    blank_q, blank_d;
  logic [CNT_W-1:0]    max_q, max_d;
  logic                smp_v_q, smp_v_d;
  logic                trig_ready_q, trig_ready_d;
  logic                res_valid_q, res_valid_d;
  logic                res_hit_q, res_hit_d;
  logic [CNT_W-1:0]    res_tof_q, res_tof_d;
  logic [SAMPLE_W-2:0] res_peak_q, res_peak_d;

  logic [SAMPLE_W-2:0] mag_s;
  logic [CNT_W-1:0]    last_idx_s;
  logic                avg_clr_s;
  logic                avg_upd_s;

  // The FIFO is drained in every state so recording never stalls.
  assign fifo_rd_en = ~fifo_empty & ~srst;

  assign trig_ready = trig_ready_q;
  assign res_valid  = res_valid_q;
  assign res_hit    = res_hit_q;
  assign res_tof    = res_tof_q;
  assign res_peak   = res_peak_q;

  echo_mag #(
    .SAMPLE_W (SAMPLE_W)
  ) u_mag (
    .clk    (bus_clk),
    .srst   (srst),
    .ch_sel (ch_sel_q),
    .data   (fifo_data),
    .clr    (avg_clr_s),
    .upd    (avg_upd_s),
    .mag    (mag_s)
  );

  // Measurement FSM next-state and result computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_sel_d    = ch_sel_q;
    thr_d       = thr_q;
    blank_d     = blank_q;
    max_d       = max_q;
    res_valid_d = res_valid_q;
    res_hit_d   = res_hit_q;
    res_tof_d   = res_tof_q;
    res_peak_d  = res_peak_q;
    avg_clr_s   = 1'b0;
    avg_upd_s   = 1'b0;
    smp_v_d     = fifo_rd_en;
    // Wraps for max_samples == 0, giving a 2^CNT_W sample search.
    last_idx_s  = max_q - {{(CNT_W-1){1'b0}}, 1'b1};

    case (state_q)
      IDLE: begin
        if (trig_valid && trig_ready_q) begin
          state_d   = SEARCH;
          cnt_d     = {CNT_W{1'b0}};
          ch_sel_d  = ch_sel;
          thr_d     = threshold;
          blank_d   = blank_len;
          max_d     = max_samples;
          avg_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (smp_v_q) begin
          avg_upd_s = 1'b1;
          if ((cnt_q >= blank_q) && (mag_s > thr_q)) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_hit_d   = 1'b1;
            res_tof_d   = cnt_q;
            res_peak_d  = mag_s;
          end else if (cnt_q == last_idx_s) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_hit_d   = 1'b0;
            res_tof_d   = max_q;
            res_peak_d  = {(SAMPLE_W-1){1'b0}};
          end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: begin
        if (res_valid_q && res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    trig_ready_d = (state_d == IDLE);
  end

  // State, configuration and registered result outputs.
  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      ch_sel_q     <= CH_LEFT;
      thr_q        <= {(SAMPLE_W-1){1'b0}};
      blank_q      <= {CNT_W{1'b0}};
      max_q        <= {CNT_W{1'b0}};
      smp_v_q      <= 1'b0;
      trig_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_tof_q    <= {CNT_W{1'b0}};
      res_peak_q   <= {(SAMPLE_W-1){1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_sel_q     <= ch_sel_d;
      thr_q        <= thr_d;
      blank_q      <= blank_d;
      max_q        <= max_d;
      smp_v_q      <= smp_v_d;
      trig_ready_q <= trig_ready_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_tof_q    <= res_tof_d;
      res_peak_q   <= res_peak_d;
    end
  end

endmodule

// File: tb/tb_echo_tof_detector.sv
// tb_echo_tof_detector: directed self-checking bench for echo_tof_detector.
// A simple standard-mode FIFO model feeds words; stall forces empty gaps.
module tb_echo_tof_detector;

  logic        bus_clk = 1'b0;
  logic        srst;
  logic        fifo_rd_en;
  logic [31:0] fifo_data = 32'h0;
  logic        fifo_empty;
  logic        trig_valid;
  logic        trig_ready;
  logic        ch_sel;
  logic [14:0] threshold;
  logic [15:0] blank_len;
  logic [15:0] max_samples;
  logic        res_valid;
  logic        res_ready;
  logic        res_hit;
  logic [15:0] res_tof;
  logic [14:0] res_peak;

  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        stall = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  echo_tof_detector dut (
    .bus_clk     (bus_clk),
    .srst        (srst),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .trig_valid  (trig_valid),
    .trig_ready  (trig_ready),
    .ch_sel      (ch_sel),
    .threshold   (threshold),
    .blank_len   (blank_len),
    .max_samples (max_samples),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_hit     (res_hit),
    .res_tof     (res_tof),
    .res_peak    (res_peak)
  );

  always #5 bus_clk = ~bus_clk;

  assign fifo_empty = (rd_ptr == wr_ptr) || stall;

  // FIFO read side: data appears the cycle after the read strobe.
  always @(posedge bus_clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge bus_clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_left(input logic [15:0] l);
    push({l, 16'h7FFF});
  endtask

  task automatic do_trig(input logic ch, input logic [14:0] thr,
                         input logic [15:0] bl, input logic [15:0] mx);
    ch_sel      = ch;
    threshold   = thr;
    blank_len   = bl;
    max_samples = mx;
    trig_valid  = 1'b1;
    check_val("trig_ready_idle", {31'd0, trig_ready}, 32'd1);
    step(1);
    trig_valid  = 1'b0;
    // Scramble the live config: the DUT must use the latched copy.
    ch_sel      = ~ch;
    threshold   = 15'd0;
    blank_len   = 16'd0;
    max_samples = 16'd1;
    check_val("trig_ready_busy", {31'd0, trig_ready}, 32'd0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check_val("valid_drop", {31'd0, res_valid}, 32'd0);
    check_val("ready_after_acc", {31'd0, trig_ready}, 32'd1);
  endtask

  task automatic check_res(input string tag, input logic hit,
                           input logic [15:0] tof, input logic [14:0] pk);
    check_val({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
    check_val({tag, "_hit"},   {31'd0, res_hit},   {31'd0, hit});
    check_val({tag, "_tof"},   {16'd0, res_tof},   {16'd0, tof});
    check_val({tag, "_peak"},  {17'd0, res_peak},  {17'd0, pk});
  endtask

  initial begin
    int          base;
    logic [15:0] tof_exp;
    logic [14:0] pk_exp;
    logic        hit_exp;

    srst        = 1'b1;
    trig_valid  = 1'b0;
    res_ready   = 1'b0;
    ch_sel      = 1'b0;
    threshold   = 15'd0;
    blank_len   = 16'd0;
    max_samples = 16'd0;

    // Reset state; words pushed during reset must not be read.
    step(2);
    for (int i = 0; i < 10; i++) push_left(16'(i * 100));
    step(1);
    check_val("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
    check_val("rst_trig_rdy",{31'd0, trig_ready}, 32'd0);
    check_val("rst_valid",   {31'd0, res_valid},  32'd0);
    check_val("rst_hit",     {31'd0, res_hit},    32'd0);
    check_val("rst_tof",     {16'd0, res_tof},    32'd0);
    check_val("rst_peak",    {17'd0, res_peak},   32'd0);
    check_val("rst_no_read", rd_ptr,              32'd0);

    // Idle draining without a trigger.
    srst = 1'b0;
    step(1);
    check_val("idle_trig_rdy", {31'd0, trig_ready}, 32'd1);
    step(12);
    check_val("idle_drained", rd_ptr, 32'd10);
    check_val("idle_valid",   {31'd0, res_valid}, 32'd0);

    // Hit after blanking, exact latency.
    do_trig(1'b0, 15'd1000, 16'd5, 16'd100);
    push_left(16'd0); push_left(16'd0); push_left(16'd0); push_left(16'd2000);
    push_left(16'd0); push_left(16'd0); push_left(16'd0); push_left(16'd1500);
    step(8);
    check_val("lat_not_yet", {31'd0, res_valid}, 32'd0);
    step(1);
    check_res("hit7", 1'b1, 16'd7, 15'd1500);
    accept();

    // Timeout after exactly 100 samples, with empty gaps.
    do_trig(1'b0, 15'd1000, 16'd5, 16'd100);
    for (int i = 0; i < 99; i++) begin
      case (i % 3)
        0:       push_left(16'd1000);
        1:       push_left(16'hFC18);
        default: push_left(16'd7);
      endcase
    end
    for (int i = 0; i < 250; i++) begin
      stall = (i % 3 == 0);
      step(1);
    end
    stall = 1'b0;
    check_val("to_99_no_res", {31'd0, res_valid}, 32'd0);
    push_left(16'd999);
    step(2);
    check_res("timeout", 1'b0, 16'd100, 15'd0);
    accept();

    // Right channel, most negative value saturates, index 0.
    do_trig(1'b1, 15'h7FFE, 16'd0, 16'd10);
    push({16'h0001, 16'h8000});
    step(2);
    check_res("sat", 1'b1, 16'd0, 15'h7FFF);

    // Result held, FIFO drains, trigger in DONE ignored.
    base = rd_ptr;
    for (int i = 0; i < 5; i++) push_left(16'h7000);
    trig_valid = 1'b1;
    step(5);
    trig_valid = 1'b0;
    step(15);
    check_val("hold_drain", rd_ptr - base, 32'd5);
    check_val("hold_trig_rdy", {31'd0, trig_ready}, 32'd0);
    check_res("hold", 1'b1, 16'd0, 15'h7FFF);
    accept();

    // blank_len >= max_samples: timeout only.
    do_trig(1'b0, 15'd1000, 16'd5, 16'd4);
    for (int i = 0; i < 4; i++) push_left(16'd30000);
    step(6);
    check_res("blank_ge_max", 1'b0, 16'd4, 15'd0);
    accept();

    // srst mid-search drops the in-flight sample.
    do_trig(1'b0, 15'd1000, 16'd0, 16'd100);
    for (int i = 0; i < 3; i++) push_left(16'd100);
    step(5);
    push_left(16'd5000);
    step(1);
    srst = 1'b1;
    step(1);
    check_val("srst_valid",   {31'd0, res_valid},  32'd0);
    check_val("srst_hit",     {31'd0, res_hit},    32'd0);
    check_val("srst_trig_rdy",{31'd0, trig_ready}, 32'd0);
    srst = 1'b0;
    step(3);
    check_val("post_srst_valid", {31'd0, res_valid}, 32'd0);
    do_trig(1'b0, 15'd1000, 16'd2, 16'd100);
    push_left(16'd0); push_left(16'd0); push_left(16'd0); push_left(16'd3000);
    step(6);
    check_res("restart", 1'b1, 16'd3, 15'd3000);
    accept();

    // Magnitude 4000 against thresholds 999 and 1000 (raw or averaged).
    do_trig(1'b0, 15'd999, 16'd0, 16'd10);
    push_left(16'd4000); push_left(16'd0); push_left(16'd0); push_left(16'd0);
    step(6);
`ifdef ECHO_AVG_EN
    pk_exp = 15'd1000;
`else
    pk_exp = 15'd4000;
`endif
    check_res("avg999", 1'b1, 16'd0, pk_exp);
    accept();
    step(4);
    do_trig(1'b0, 15'd1000, 16'd0, 16'd4);
    push_left(16'd4000); push_left(16'd0); push_left(16'd0); push_left(16'd0);
    step(7);
`ifdef ECHO_AVG_EN
    hit_exp = 1'b0; tof_exp = 16'd4; pk_exp = 15'd0;
`else
    hit_exp = 1'b1; tof_exp = 16'd0; pk_exp = 15'd4000;
`endif
    check_res("avg1000", hit_exp, tof_exp, pk_exp);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
